// File: rtl/mem_ctrl_if.sv
// mem_ctrl_if: bundle of the fetch port, the load/store port and the
// byte-wide RAM bus that mem_ctrl serves.
//   slave  : the controller side (takes requests and RAM read data, drives
//            the RAM address/data/write strobe and the done/data responses)
//   master : the system side (requesters plus the RAM model)
interface mem_ctrl_if;
    // RAM bus
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    // instruction fetch port
    logic        if_req_in;
    logic [31:0] if_addr_in;
    logic        if_done_out;
    logic [31:0] if_data_out;
    // load/store port
    logic        ls_req_in;
    logic        ls_wr_in;
    logic [1:0]  ls_size_in;
    logic [31:0] ls_addr_in;
    logic [31:0] ls_wdata_in;
    logic        ls_done_out;
    logic [31:0] ls_rdata_out;

    modport slave (
        input  mem_din,
        input  if_req_in, if_addr_in,
        input  ls_req_in, ls_wr_in, ls_size_in, ls_addr_in, ls_wdata_in,
        output mem_dout, mem_a, mem_wr,
        output if_done_out, if_data_out,
        output ls_done_out, ls_rdata_out
    );

    modport master (
        output mem_din,
        output if_req_in, if_addr_in,
        output ls_req_in, ls_wr_in, ls_size_in, ls_addr_in, ls_wdata_in,
        input  mem_dout, mem_a, mem_wr,
        input  if_done_out, if_data_out,
        input  ls_done_out, ls_rdata_out
    );
endinterface

// File: rtl/mem_ctrl.sv
// mem_ctrl: byte-serial memory controller / arbiter. Shares one 8-bit RAM
// port between the instruction fetch path (word reads) and the load/store
// unit (1/2/4-byte reads and writes). Accesses are sequenced one byte per
// cycle, little-endian, and finish with a one-cycle done pulse. When both
// sides are waiting, the side not served last time is granted.
// Ports:
//   clk_in    system clock (rising edge)
//   rst_in    synchronous active-low reset (wins over rdy_in and clear_in)
//   rdy_in    global ready; low freezes all state and masks mem_wr
//   clear_in  flush: aborts reads in flight, blocks a grant in IDLE
//   bus       mem_ctrl_if.slave (RAM bus, fetch port, load/store port)
module mem_ctrl (
    input logic       clk_in,
    input logic       rst_in,
    input logic       rdy_in,
    input logic       clear_in,
    mem_ctrl_if.slave bus
);

    typedef enum logic [1:0] {IDLE, IF_RD, LS_RD, LS_WR} state_t;

    state_t      state_q, state_d;
    logic [2:0]  cnt_q;        // index of the byte currently on the bus
    logic [2:0]  len_q;        // bytes in this access: 1, 2 or 4
    logic [31:0] buf_q;        // read assembly / write data holding register
    logic        last_ls_q;    // 1: load/store was granted last, 0: fetch
    logic        mem_wr_q;
    logic [31:0] mem_a_q;
    logic [7:0]  mem_dout_q;
    logic        if_done_q, ls_done_q;
    logic [31:0] if_data_q, ls_data_q;

    logic        grant_if, grant_ls, last_byte;
    logic [2:0]  cnt_inc;
    logic [4:0]  rd_sel, wr_sel;
    logic [31:0] rd_word;

    function automatic logic [2:0] size_len(input logic [1:0] size);
        case (size)
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    // Read data with the byte arriving this cycle merged in; this is what
    // gets published on the final byte so no extra cycle is needed.
    always_comb begin
        cnt_inc = cnt_q + 3'd1;
        rd_sel  = {cnt_q[1:0], 3'b000};
        wr_sel  = {cnt_inc[1:0], 3'b000};
        rd_word = buf_q;
        rd_word[rd_sel +: 8] = bus.mem_din;
    end

    // State register
    always_ff @(posedge clk_in) begin
        if (!rst_in)
            state_q <= IDLE;
        else if (rdy_in)
            state_q <= state_d;
    end

    // Next state and grant decision
    always_comb begin
        state_d   = state_q;
        grant_if  = 1'b0;
        grant_ls  = 1'b0;
        last_byte = (cnt_q == len_q - 3'd1);
        case (state_q)
            IDLE: begin
                // A done pulse in flight means the requester has not had a
                // chance to drop its request yet, so hold off one cycle.
                if (!clear_in && !if_done_q && !ls_done_q) begin
                    if (bus.if_req_in && (!bus.ls_req_in || last_ls_q))
                        grant_if = 1'b1;
                    else if (bus.ls_req_in)
                        grant_ls = 1'b1;
                end
                if (grant_if)
                    state_d = IF_RD;
                else if (grant_ls)
                    state_d = bus.ls_wr_in ? LS_WR : LS_RD;
            end
            IF_RD, LS_RD: begin
                if (clear_in || last_byte)
                    state_d = IDLE;
            end
            LS_WR: begin
                // Stores are committed once started; flush does not stop them.
                if (last_byte)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            cnt_q      <= 3'd0;
            len_q      <= 3'd1;
            buf_q      <= 32'd0;
            last_ls_q  <= 1'b0;
            mem_wr_q   <= 1'b0;
            mem_a_q    <= 32'd0;
            mem_dout_q <= 8'd0;
            if_done_q  <= 1'b0;
            ls_done_q  <= 1'b0;
            if_data_q  <= 32'd0;
            ls_data_q  <= 32'd0;
        end else if (rdy_in) begin
            if_done_q <= 1'b0;
            ls_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (grant_if) begin
                        mem_a_q   <= bus.if_addr_in;
                        cnt_q     <= 3'd0;
                        len_q     <= 3'd4;
                        buf_q     <= 32'd0;
                        mem_wr_q  <= 1'b0;
                        last_ls_q <= 1'b0;
                    end else if (grant_ls) begin
                        mem_a_q    <= bus.ls_addr_in;
                        cnt_q      <= 3'd0;
                        len_q      <= size_len(bus.ls_size_in);
                        // Loads start from zero so short loads come out
                        // zero-extended.
                        buf_q      <= bus.ls_wr_in ? bus.ls_wdata_in : 32'd0;
                        mem_dout_q <= bus.ls_wdata_in[7:0];
                        mem_wr_q   <= bus.ls_wr_in;
                        last_ls_q  <= 1'b1;
                    end
                end
                IF_RD, LS_RD: begin
                    if (!clear_in) begin
                        buf_q <= rd_word;
                        if (last_byte) begin
                            // mem_a is left on the last address
                            if (state_q == IF_RD) begin
                                if_data_q <= rd_word;
                                if_done_q <= 1'b1;
                            end else begin
                                ls_data_q <= rd_word;
                                ls_done_q <= 1'b1;
                            end
                        end else begin
                            cnt_q   <= cnt_inc;
                            mem_a_q <= mem_a_q + 32'd1;
                        end
                    end
                end
                LS_WR: begin
                    if (last_byte) begin
                        mem_wr_q  <= 1'b0;
                        ls_done_q <= 1'b1;
                    end else begin
                        cnt_q      <= cnt_inc;
                        mem_a_q    <= mem_a_q + 32'd1;
                        mem_dout_q <= buf_q[wr_sel +: 8];
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs; the write strobe is masked while the system is stalled so the
    // RAM never sees a write during a frozen cycle.
    always_comb begin
        bus.mem_wr       = mem_wr_q & rdy_in;
        bus.mem_a        = mem_a_q;
        bus.mem_dout     = mem_dout_q;
        bus.if_done_out  = if_done_q;
        bus.if_data_out  = if_data_q;
        bus.ls_done_out  = ls_done_q;
        bus.ls_rdata_out = ls_data_q;
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: byte-addressed RAM model on the bus, transaction-level
// reference memory, directed corner cases plus randomized traffic.
module tb_mem_ctrl;
    logic clk_in = 1'b0;
    logic rst_in = 1'b0;
    logic rdy_in = 1'b1;
    logic clear_in = 1'b0;

    mem_ctrl_if bus();

    mem_ctrl dut (
        .clk_in  (clk_in),
        .rst_in  (rst_in),
        .rdy_in  (rdy_in),
        .clear_in(clear_in),
        .bus     (bus)
    );

    always #5 clk_in = ~clk_in;

    logic [7:0]  ram  [logic [31:0]];   // what the DUT actually wrote
    logic [7:0]  gold [logic [31:0]];   // what memory should contain
    int          n_chk = 0;
    int          n_pass = 0;
    logic [31:0] last_data;
    int          who [4];
    int          when [4];

    function automatic logic [7:0] bg(input logic [31:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction
    function automatic logic [7:0] ram_rd(input logic [31:0] a);
        return ram.exists(a) ? ram[a] : bg(a);
    endfunction
    function automatic logic [7:0] gold_rd(input logic [31:0] a);
        return gold.exists(a) ? gold[a] : bg(a);
    endfunction
    function automatic logic [31:0] exp_rd(input logic [31:0] addr, input int len);
        logic [31:0] v = 32'd0;
        for (int k = 0; k < len; k++) v = v | (32'(gold_rd(addr + 32'(k))) << (8 * k));
        return v;
    endfunction
    function automatic int len_of(input bit is_if, input logic [1:0] size);
        if (is_if) return 4;
        return (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
    endfunction

    // RAM: read data settles during the cycle the address is presented
    always @(negedge clk_in) bus.mem_din = ram_rd(bus.mem_a);
    always @(posedge clk_in) if (bus.mem_wr) ram[bus.mem_a] = bus.mem_dout;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    // One access from request to done. clr_at/stall_at are cycle indices
    // (1 = first cycle after the grant edge) at which to pulse clear_in or
    // drop rdy_in for stall_n cycles.
    task automatic do_txn(input bit is_if, input bit wr, input logic [1:0] size,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input int clr_at, input int stall_at, input int stall_n);
        int   len, c, wcnt;
        bit   abort, done, stalled, got;
        logic [31:0] prev_a, data;
        len   = len_of(is_if, size);
        abort = (clr_at > 0) && (is_if || !wr);
        if (is_if) begin
            bus.if_req_in = 1'b1; bus.if_addr_in = addr;
        end else begin
            bus.ls_req_in = 1'b1; bus.ls_wr_in = wr; bus.ls_size_in = size;
            bus.ls_addr_in = addr; bus.ls_wdata_in = wdata;
        end
        c = 0; wcnt = 0; done = 0; stalled = 0; prev_a = 32'd0; data = 32'd0;
        while (!done && c < (abort ? 12 : 40)) begin
            @(negedge clk_in);
            c++;
            if (bus.mem_wr) begin
                chk("wr_addr", bus.mem_a, addr + 32'(wcnt));
                chk("wr_byte", 32'(bus.mem_dout), (wdata >> (8 * wcnt)) & 32'hFF);
                wcnt++;
            end
            if (stalled) chk("stall_addr", bus.mem_a, prev_a);
            got  = is_if ? bus.if_done_out : bus.ls_done_out;
            data = is_if ? bus.if_data_out : bus.ls_rdata_out;
            if (got) begin
                done = 1;
                break;
            end
            clear_in = (c == clr_at);
            if (abort && c == clr_at) begin
                bus.if_req_in = 1'b0; bus.ls_req_in = 1'b0;
            end
            rdy_in  = !(c >= stall_at && c < stall_at + stall_n);
            stalled = !rdy_in;
            prev_a  = bus.mem_a;
            if (!rdy_in) begin
                #1 chk("stall_wr", 32'(bus.mem_wr), 32'd0);
            end
        end
        bus.if_req_in = 1'b0; bus.ls_req_in = 1'b0;
        clear_in = 1'b0; rdy_in = 1'b1;
        if (abort) begin
            chk("abort_no_done", 32'(done), 32'd0);
        end else begin
            chk("done_seen", 32'(done), 32'd1);
            chk("latency", 32'(c), 32'(len + 1 + stall_n));
            chk("wr_count", 32'(wcnt), wr ? 32'(len) : 32'd0);
            if (wr) begin
                for (int k = 0; k < len; k++) gold[addr + 32'(k)] = wdata[8*k +: 8];
                for (int k = 0; k < len; k++)
                    chk("st_mem", 32'(ram_rd(addr + 32'(k))), 32'(gold_rd(addr + 32'(k))));
            end else begin
                chk(is_if ? "if_data" : "ls_data", data, exp_rd(addr, len));
            end
            last_data = data;
            @(negedge clk_in);
            chk("pulse_width", 32'(is_if ? bus.if_done_out : bus.ls_done_out), 32'd0);
        end
    endtask

    initial begin
        int c, nev, both;
        bit seen;
        bus.if_req_in = 0; bus.if_addr_in = 0; bus.ls_req_in = 0; bus.ls_wr_in = 0;
        bus.ls_size_in = 0; bus.ls_addr_in = 0; bus.ls_wdata_in = 0;

        // reset state
        repeat (3) @(negedge clk_in);
        chk("rst_mem_a", bus.mem_a, 32'd0);
        chk("rst_mem_wr", 32'(bus.mem_wr), 32'd0);
        chk("rst_mem_dout", 32'(bus.mem_dout), 32'd0);
        chk("rst_if_done", 32'(bus.if_done_out), 32'd0);
        chk("rst_ls_done", 32'(bus.ls_done_out), 32'd0);
        chk("rst_if_data", bus.if_data_out, 32'd0);
        chk("rst_ls_data", bus.ls_rdata_out, 32'd0);
        rst_in = 1'b1;
        @(negedge clk_in);

        // word fetch of a known instruction
        ram[32'h1000] = 8'h13; ram[32'h1001] = 8'h05; ram[32'h1002] = 8'h00; ram[32'h1003] = 8'h00;
        gold[32'h1000] = 8'h13; gold[32'h1001] = 8'h05; gold[32'h1002] = 8'h00; gold[32'h1003] = 8'h00;
        do_txn(1, 0, 2'b00, 32'h1000, 32'd0, 0, 0, 0);
        chk("fetch_insn", last_data, 32'h0000_0513);

        // half store, then byte load of its upper byte
        do_txn(0, 1, 2'b01, 32'h20, 32'hAABBCCDD, 0, 0, 0);
        chk("half_no_spill", 32'(ram_rd(32'h22)), 32'(bg(32'h22)));
        do_txn(0, 0, 2'b00, 32'h21, 32'd0, 0, 0, 0);
        chk("byte_load", last_data, 32'h0000_00CC);

        // randomized single-requester traffic
        for (int i = 0; i < 40; i++) begin
            bit isf = ($urandom_range(0, 3) == 0);
            if (isf)
                do_txn(1, 0, 2'b00, 32'h100 + 32'($urandom_range(0, 63) * 4), 32'd0, 0, 0, 0);
            else
                do_txn(0, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                       32'h100 + 32'($urandom_range(0, 255)), $urandom, 0, 0, 0);
        end

        // 32-bit address wrap
        do_txn(0, 1, 2'b10, 32'hFFFF_FFFE, 32'h11223344, 0, 0, 0);
        chk("wrap_byte0", 32'(ram_rd(32'h0)), 32'h22);
        do_txn(0, 0, 2'b10, 32'hFFFF_FFFE, 32'd0, 0, 0, 0);

        // flush during a fetch aborts it; flush during a store does not
        do_txn(1, 0, 2'b00, 32'h140, 32'd0, 2, 0, 0);
        do_txn(0, 1, 2'b10, 32'h150, 32'hCAFEF00D, 2, 0, 0);
        do_txn(0, 0, 2'b10, 32'h150, 32'd0, 0, 0, 0);
        chk("flush_store", last_data, 32'hCAFEF00D);

        // stalls mid load and mid store
        do_txn(0, 0, 2'b10, 32'h180, 32'd0, 0, 2, 3);
        do_txn(0, 1, 2'b10, 32'h1C0, $urandom, 0, 2, 2);

        // contention from reset: LS first, then alternating
        rst_in = 1'b0;
        bus.if_req_in = 1; bus.if_addr_in = 32'h400;
        bus.ls_req_in = 1; bus.ls_wr_in = 0; bus.ls_size_in = 2'b10; bus.ls_addr_in = 32'h300;
        repeat (2) @(negedge clk_in);
        rst_in = 1'b1;
        c = 0; nev = 0; both = 0;
        while (nev < 4 && c < 60) begin
            @(negedge clk_in);
            c++;
            if (bus.if_done_out && bus.ls_done_out) both++;
            if (bus.ls_done_out) begin
                chk("cont_ls_data", bus.ls_rdata_out, exp_rd(32'h300, 4));
                who[nev] = 1; when[nev] = c; nev++;
            end else if (bus.if_done_out) begin
                chk("cont_if_data", bus.if_data_out, exp_rd(32'h400, 4));
                who[nev] = 0; when[nev] = c; nev++;
            end
        end
        bus.if_req_in = 0; bus.ls_req_in = 0;
        chk("cont_events", 32'(nev), 32'd4);
        chk("cont_overlap", 32'(both), 32'd0);
        if (nev == 4) begin
            for (int k = 0; k < 4; k++) chk("cont_order", 32'(who[k]), (k % 2 == 0) ? 32'd1 : 32'd0);
            chk("cont_first", 32'(when[0]), 32'd5);
            for (int k = 1; k < 4; k++) chk("cont_gap", 32'(when[k] - when[k-1]), 32'd6);
        end
        @(negedge clk_in);

        // reset in the middle of a word store
        bus.ls_req_in = 1; bus.ls_wr_in = 1; bus.ls_size_in = 2'b10;
        bus.ls_addr_in = 32'h8000_0000; bus.ls_wdata_in = $urandom;
        repeat (3) @(negedge clk_in);
        chk("rstw_writing", 32'(bus.mem_wr), 32'd1);
        rst_in = 1'b0;
        @(negedge clk_in);
        chk("rstw_mem_wr", 32'(bus.mem_wr), 32'd0);
        chk("rstw_mem_a", bus.mem_a, 32'd0);
        chk("rstw_mem_dout", 32'(bus.mem_dout), 32'd0);
        chk("rstw_ls_done", 32'(bus.ls_done_out), 32'd0);
        chk("rstw_ls_data", bus.ls_rdata_out, 32'd0);
        chk("rstw_if_data", bus.if_data_out, 32'd0);
        rst_in = 1'b1; bus.ls_req_in = 0;
        seen = 0;
        repeat (8) begin
            @(negedge clk_in);
            if (bus.ls_done_out || bus.if_done_out || bus.mem_wr) seen = 1;
        end
        chk("rstw_quiet", 32'(seen), 32'd0);
        do_txn(0, 0, 2'b00, 32'h21, 32'd0, 0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
